alu_arb_444: RTL and testbench
==============================

# alu_arb_444

Two-requester arbiter and sequencer that shares a single instance of the 8-bit, 3-bit-select combinational ALU (`circ_444`) between two clients. Each client issues an operation (A, B, sel) over a valid/ready request channel. The block grants the ALU round-robin, drives the ALU operands from registers, captures the result one cycle later, and returns it on the winning client's response channel. Only one operation is in flight at a time.

## Interface
Parameters:
- `RR_EN`, default 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 wins.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `req_valid_i2`  in  2  per-port request valid; bit p belongs to port p.
- `req_ready_o2`  out  2  per-port request ready; combinational, at most one bit high.
- `req_A0_i8`, `req_B0_i8`  in  8 each  port 0 operands.
- `req_sel0_i3`  in  3  port 0 function select.
- `req_A1_i8`, `req_B1_i8`  in  8 each  port 1 operands.
- `req_sel1_i3`  in  3  port 1 function select.
- `alu_A_o8`, `alu_B_o8`  out  8 each  registered operands to the ALU.
- `alu_sel_o3`  out  3  registered select to the ALU.
- `alu_y_i8`  in  8  ALU result (combinational from `alu_*_o*`).
- `rsp_valid_o2`  out  2  per-port response valid; at most one bit high.
- `rsp_ready_i2`  in  2  per-port response ready.
- `rsp_y_o8`  out  8  result, shared by both ports, qualified by `rsp_valid_o2`.
- `busy_o`  out  1  high in EXEC or RESP.
- `op_cnt_o8`  out  8  completed-operation counter, wraps 255 -> 0.

## Operation
- State machine: IDLE, EXEC, RESP.
- **IDLE**
  - Grant vector g is computed combinationally from `req_valid_i2` and the last-served pointer `last`.
  - One port valid: that port is granted.
  - Both valid, `RR_EN=1`: the port != `last` is granted.
  - Both valid, `RR_EN=0`: port 0 is granted.
  - `req_ready_o2 = g`.
  - On handshake (valid & ready on port p): latch that port's A, B and sel into the operand registers, store `id = p`, go to EXEC.
  - No handshake: stay in IDLE.
- **EXEC**
  - `alu_*` outputs already show the latched operands.
  - Capture `alu_y_i8` into the result register and go to RESP.
  - `req_ready_o2 = 0`.
- **RESP**
  - `rsp_valid_o2[id] = 1` and `rsp_y_o8 = result`; both stay stable until accepted.
  - On `rsp_ready_i2[id]`: `last <= id`, `op_cnt_o8 <= op_cnt_o8 + 1` (mod 256), go to IDLE.
  - `rsp_ready_i2` on the other port is ignored.
  - `req_ready_o2 = 0`.
- The operand registers keep their value after an operation until the next handshake. The ALU outputs never glitch between operations.
- `busy_o = (state != IDLE)`.

## Timing
- Reset (`rst_ni` low, asynchronous) sets:
  - state = IDLE;
  - `alu_A_o8`, `alu_B_o8`, `alu_sel_o3`, `rsp_y_o8` = 0;
  - `rsp_valid_o2` = 2'b00, `busy_o` = 0, `op_cnt_o8` = 0;
  - `last` = 1, so port 0 wins the first contention.
- `req_ready_o2` is 0 while `rst_ni` is low.
- Latency: handshake at edge N; result captured at edge N+1; `rsp_valid_o2` high after edge N+1. If the client's ready is already high, the response completes at edge N+2.
- Maximum throughput is one operation per 3 cycles. A back-to-back request is accepted in the cycle after the response handshake.
- Reset asserted in EXEC or RESP aborts the transaction: no response, and the counter does not increment.
- A request valid dropped before grant is allowed and has no effect. Operands are sampled only at the handshake edge.
- A requester that changes operands while waiting in RESP does not affect `rsp_y_o8`.

## Test plan
Bench stub: `alu_y_i8 = alu_A_o8 + alu_B_o8` (mod 256), combinational.
- Reset: hold `rst_ni=0` with both requests valid -> all outputs 0, `req_ready_o2 = 00`. Release -> `req_ready_o2 = 01`.
- Single op: port 1 issues A=8'h10, B=8'h05, sel=3 with `rsp_ready_i2 = 11`:
  - handshake at edge N;
  - `alu_sel_o3 = 3` after N;
  - `rsp_valid_o2 = 10` and `rsp_y_o8 = 8'h15` after N+1;
  - `op_cnt_o8 = 1` after N+2.
- Contention, `RR_EN=1`: both ports continuously valid with distinct operands -> grants alternate 0,1,0,1; each response matches its own port's sum; one op per 3 cycles.
- Contention, `RR_EN=0`: both valid for 4 ops -> port 0 served 4 times; port 1 is never granted.
- Response backpressure: hold `rsp_ready_i2 = 00` for 5 cycles, with A=8'hFF, B=8'h02 -> `rsp_y_o8` stays 8'h01 and `rsp_valid_o2` stays asserted, `req_ready_o2 = 00`, no new grant. Release -> completes.
- Abort and wrap:
  - pulse `rst_ni` low during EXEC -> no response, `op_cnt_o8 = 0`;
  - then run 256 ops -> `op_cnt_o8` wraps to 0.

Source files
------------

// File: rtl/alu_arb_444.sv
// Two-client arbiter/sequencer sharing one combinational 8-bit ALU.
// Grants round-robin (or fixed priority), registers operands, returns the result to the winner.
`timescale 1ns/1ps

module alu_arb_444 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_valid_i2,
  output logic [1:0] req_ready_o2,
  input  logic [7:0] req_A0_i8,
  input  logic [7:0] req_B0_i8,
  input  logic [2:0] req_sel0_i3,
  input  logic [7:0] req_A1_i8,
  input  logic [7:0] req_B1_i8,
  input  logic [2:0] req_sel1_i3,
  output logic [7:0] alu_A_o8,
  output logic [7:0] alu_B_o8,
  output logic [2:0] alu_sel_o3,
  input  logic [7:0] alu_y_i8,
  output logic [1:0] rsp_valid_o2,
  input  logic [1:0] rsp_ready_i2,
  output logic [7:0] rsp_y_o8,
  output logic       busy_o,
  output logic [7:0] op_cnt_o8
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state;
  logic       id;
  logic       last;
  logic [1:0] grant;
  logic       req_hs;

  // Grant only in IDLE; on contention the port not served last wins (or port 0 in fixed mode).
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      case (req_valid_i2)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (RR_EN && !last) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready_o2 = rst_ni ? grant : 2'b00;
  assign req_hs       = |(req_valid_i2 & grant);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      id           <= 1'b0;
      last         <= 1'b1;
      alu_A_o8     <= 8'd0;
      alu_B_o8     <= 8'd0;
      alu_sel_o3   <= 3'd0;
      rsp_y_o8     <= 8'd0;
      rsp_valid_o2 <= 2'b00;
      busy_o       <= 1'b0;
      op_cnt_o8    <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            id     <= grant[1];
            busy_o <= 1'b1;
            state  <= EXEC;
            if (grant[1]) begin
              alu_A_o8   <= req_A1_i8;
              alu_B_o8   <= req_B1_i8;
              alu_sel_o3 <= req_sel1_i3;
            end else begin
              alu_A_o8   <= req_A0_i8;
              alu_B_o8   <= req_B0_i8;
              alu_sel_o3 <= req_sel0_i3;
            end
          end
        end
        EXEC: begin
          rsp_y_o8     <= alu_y_i8;
          rsp_valid_o2 <= {id, ~id};
          state        <= RESP;
        end
        RESP: begin
          // Only the owning port's ready completes the response.
          if (rsp_ready_i2[id]) begin
            rsp_valid_o2 <= 2'b00;
            busy_o       <= 1'b0;
            last         <= id;
            op_cnt_o8    <= op_cnt_o8 + 8'd1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arb_444.sv
// Self-checking bench for alu_arb_444: transaction-level reference model plus directed and random phases.
`timescale 1ns/1ps

module tb_alu_arb_444;

  logic       clk = 1'b0;
  logic       rst_n;
  always #5 clk = ~clk;

  // Round-robin instance signals
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [7:0] a0, b0, a1, b1, alu_a, alu_b, alu_y, rsp_y, op_cnt;
  logic [2:0] s0, s1, alu_s;
  logic       busy;

  // Fixed-priority instance signals
  logic [1:0] fp_valid, fp_ready, fp_rsp_valid, fp_rsp_ready;
  logic [7:0] fp_a0, fp_b0, fp_a1, fp_b1, fp_alu_a, fp_alu_b, fp_alu_y, fp_rsp_y, fp_cnt;
  logic [2:0] fp_s0, fp_s1, fp_alu_s;
  logic       fp_busy;

  assign alu_y    = alu_a + alu_b;
  assign fp_alu_y = fp_alu_a + fp_alu_b;

  alu_arb_444 #(.RR_EN(1'b1)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i2(req_valid), .req_ready_o2(req_ready),
    .req_A0_i8(a0), .req_B0_i8(b0), .req_sel0_i3(s0),
    .req_A1_i8(a1), .req_B1_i8(b1), .req_sel1_i3(s1),
    .alu_A_o8(alu_a), .alu_B_o8(alu_b), .alu_sel_o3(alu_s), .alu_y_i8(alu_y),
    .rsp_valid_o2(rsp_valid), .rsp_ready_i2(rsp_ready), .rsp_y_o8(rsp_y),
    .busy_o(busy), .op_cnt_o8(op_cnt)
  );

  alu_arb_444 #(.RR_EN(1'b0)) u_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i2(fp_valid), .req_ready_o2(fp_ready),
    .req_A0_i8(fp_a0), .req_B0_i8(fp_b0), .req_sel0_i3(fp_s0),
    .req_A1_i8(fp_a1), .req_B1_i8(fp_b1), .req_sel1_i3(fp_s1),
    .alu_A_o8(fp_alu_a), .alu_B_o8(fp_alu_b), .alu_sel_o3(fp_alu_s), .alu_y_i8(fp_alu_y),
    .rsp_valid_o2(fp_rsp_valid), .rsp_ready_i2(fp_rsp_ready), .rsp_y_o8(fp_rsp_y),
    .busy_o(fp_busy), .op_cnt_o8(fp_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_grant(input logic [1:0] v, input logic lst);
    if (v == 2'b11) return lst ? 2'b01 : 2'b10;
    return v;
  endfunction

  // Reference model state for the round-robin instance
  int         cyc = 0;
  int         hs_cyc = 0;
  int         rsp_count = 0;
  bit         pend = 1'b0;
  logic       mport = 1'b0;
  logic       m_last = 1'b1;
  logic [7:0] m_a = 8'd0, m_b = 8'd0, ey = 8'd0, m_cnt = 8'd0;
  logic [2:0] m_s = 3'd0;
  logic       served[$];

  always @(posedge clk) begin
    logic [1:0] er, ev;
    cyc++;
    if (!rst_n) begin
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cnt", 32'(op_cnt), 32'd0);
      check("rst_alu", 32'({alu_a, alu_b, alu_s}), 32'd0);
      check("rst_y", 32'(rsp_y), 32'd0);
      pend = 1'b0; m_last = 1'b1; m_cnt = 8'd0;
      m_a = 8'd0; m_b = 8'd0; m_s = 3'd0;
    end else begin
      er = pend ? 2'b00 : exp_grant(req_valid, m_last);
      ev = (pend && cyc >= hs_cyc + 2) ? (mport ? 2'b10 : 2'b01) : 2'b00;
      check("req_ready", 32'(req_ready), 32'(er));
      check("rsp_valid", 32'(rsp_valid), 32'(ev));
      check("busy", 32'(busy), 32'(pend));
      check("op_cnt", 32'(op_cnt), 32'(m_cnt));
      check("alu_ops", 32'({alu_a, alu_b, alu_s}), 32'({m_a, m_b, m_s}));
      if (ev != 2'b00) check("rsp_y", 32'(rsp_y), 32'(ey));
      if (ev != 2'b00 && rsp_ready[mport]) begin
        pend = 1'b0; m_last = mport; m_cnt = m_cnt + 8'd1;
        rsp_count++;
        served.push_back(mport);
      end else if (!pend && |(req_valid & er)) begin
        pend = 1'b1; hs_cyc = cyc; mport = er[1];
        m_a = mport ? a1 : a0;
        m_b = mport ? b1 : b0;
        m_s = mport ? s1 : s0;
        ey  = m_a + m_b;
      end
    end
  end

  // Fixed-priority instance: count grants/responses per port
  int fp_p1_grants = 0, fp_n0 = 0, fp_n1 = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (fp_ready[1]) fp_p1_grants++;
      if (|(fp_rsp_valid & fp_rsp_ready)) begin
        if (fp_rsp_valid[1]) fp_n1++; else fp_n0++;
        check("fp_y", 32'(fp_rsp_y), fp_rsp_valid[1] ? 32'h44 : 32'h24);
      end
    end
  end

  initial begin
    int base;
    int t;
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    a0 = 8'd0; b0 = 8'd0; s0 = 3'd0; a1 = 8'd0; b1 = 8'd0; s1 = 3'd0;
    fp_valid = 2'b00; fp_rsp_ready = 2'b00;
    fp_a0 = 8'h21; fp_b0 = 8'h03; fp_s0 = 3'd2;
    fp_a1 = 8'h40; fp_b1 = 8'h04; fp_s1 = 3'd4;

    // Reset with both requests valid
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_outs_a", 32'({alu_a, alu_b, alu_s}), 32'd0);
    check("reset_outs_b", 32'({rsp_y, rsp_valid, busy, op_cnt}), 32'd0);
    rst_n = 1'b1;
    #1;
    check("release_ready", 32'(req_ready), 32'b01);
    req_valid = 2'b00;
    @(negedge clk);

    // Single op on port 1
    a1 = 8'h10; b1 = 8'h05; s1 = 3'd3; rsp_ready = 2'b11; req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00;
    check("single_sel", 32'(alu_s), 32'd3);
    @(negedge clk);
    check("single_rsp_valid", 32'(rsp_valid), 32'b10);
    check("single_rsp_y", 32'(rsp_y), 32'h15);
    @(negedge clk);
    check("single_cnt", 32'(op_cnt), 32'd1);

    // Round-robin contention: 24 cycles -> 8 alternating ops starting at port 0
    a0 = 8'h11; b0 = 8'h22; s0 = 3'd1; a1 = 8'h30; b1 = 8'h0F; s1 = 3'd5;
    served.delete();
    req_valid = 2'b11;
    repeat (24) @(negedge clk);
    req_valid = 2'b00;
    check("rr_ops", 32'(served.size()), 32'd8);
    for (int i = 0; i < served.size(); i++) check("rr_order", 32'(served[i]), 32'(i % 2));
    @(negedge clk);

    // Fixed priority contention: 12 cycles -> 4 ops, all port 0
    fp_rsp_ready = 2'b11; fp_valid = 2'b11;
    repeat (12) @(negedge clk);
    fp_valid = 2'b00;
    check("fp_port0_ops", 32'(fp_n0), 32'd4);
    check("fp_port1_ops", 32'(fp_n1), 32'd0);
    check("fp_port1_grants", 32'(fp_p1_grants), 32'd0);

    // Response backpressure; port 0 changes operands and port 1 waits meanwhile
    a0 = 8'hFF; b0 = 8'h02; s0 = 3'd6; rsp_ready = 2'b00; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b10; a0 = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rsp_ready = (i < 3) ? 2'b00 : 2'b10;
      #1;
      check("bp_y", 32'(rsp_y), 32'h01);
      check("bp_valid", 32'(rsp_valid), 32'b01);
      check("bp_ready", 32'(req_ready), 32'b00);
      @(negedge clk);
    end
    rsp_ready = 2'b01; req_valid = 2'b00;
    @(negedge clk);
    check("bp_done", 32'(rsp_valid), 32'd0);

    // Abort during EXEC
    a1 = 8'h07; b1 = 8'h08; rsp_ready = 2'b11; req_valid = 2'b10;
    @(negedge clk);
    req_valid = 2'b00; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_rsp", 32'(rsp_valid), 32'd0);
    check("abort_cnt", 32'(op_cnt), 32'd0);

    // 256 ops wrap the counter
    base = rsp_count; t = 0;
    req_valid = 2'b01;
    while (rsp_count - base < 256 && t < 2000) begin
      a0 = 8'($urandom); b0 = 8'($urandom); s0 = 3'($urandom);
      @(negedge clk);
      t++;
    end
    req_valid = 2'b00;
    check("wrap_ops", 32'(rsp_count - base), 32'd256);
    check("wrap_cnt", 32'(op_cnt), 32'd0);

    // Random traffic against the model
    repeat (1500) begin
      req_valid = 2'($urandom); rsp_ready = 2'($urandom);
      a0 = 8'($urandom); b0 = 8'($urandom); s0 = 3'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom); s1 = 3'($urandom);
      @(negedge clk);
    end
    req_valid = 2'b00; rsp_ready = 2'b11;
    repeat (4) @(negedge clk);
    check("final_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
